uart_rx_fifo_ctrl: RTL and testbench
====================================

Name: uart_rx_fifo_ctrl

Overview:
Receive-side buffer and line-status controller that sits between the UART receiver datapath and the APB register block. It captures each completed frame (data plus parity/frame flags) into a 16-entry FIFO, or a single holding register in non-FIFO mode. It sequences reads of RBR, maintains the LSR receive bits (DR, OE, PE, FE, FIFO error) and generates the receive-data-available and character-timeout interrupt requests.

Parameters:
DEPTH, 16, FIFO entries (power of 2, ≥2)
DATA_W, 8, data bits per entry
TO_CHARS, 4, idle character times before the character-timeout interrupt

Ports:
pclk  in  1  APB clock, the single clock
presetn  in  1  asynchronous active-low reset
utrrst  in  1  receiver soft reset, synchronous, active-high
fifo_en  in  1  FCR FIFO enable; 0 selects the 1-deep holding register
rx_fifo_clr  in  1  one-cycle FCR receive-FIFO clear pulse
rx_trig  in  2  trigger level: 00=1, 01=4, 10=8, 11=14 entries
rx_valid  in  1  one-cycle strobe, frame complete (receiver error_check)
rsr_data  in  DATA_W  received data, valid with rx_valid
parity_error  in  1  valid with rx_valid
frame_error  in  1  valid with rx_valid
char_tick  in  1  one-cycle pulse per character time from the baud block
rbr_rd  in  1  one-cycle APB read of RBR
lsr_rd  in  1  one-cycle APB read of LSR
rbr_data  out  DATA_W  head-entry data
dr  out  1  data ready (FIFO non-empty)
oe  out  1  overrun error, sticky
pe  out  1  parity error of head entry, sticky
fe  out  1  framing error of head entry, sticky
rx_fifo_err  out  1  at least one errored entry in FIFO
rx_level  out  $clog2(DEPTH)+1  current entry count
rda_int  out  1  receive data available interrupt request
cti_int  out  1  character timeout interrupt request

Behaviour:
- Reset (presetn low, async) and utrrst (sync): all outputs 0, pointers/count/error count/timeout counter cleared, rbr_data 0.
- Effective capacity: DEPTH when fifo_en=1, else 1. Any change of fifo_en flushes the FIFO as for rx_fifo_clr.
- Push: rx_valid and not full -> write {rsr_data, parity_error, frame_error} at wr_ptr. rx_level/dr update on the next cycle.
- Overrun: rx_valid when full and no same-cycle rbr_rd -> entry discarded, FIFO unchanged, oe=1 next cycle.
- Pop: rbr_rd when non-empty -> rd_ptr advances, and the next entry appears on rbr_data the following cycle. rbr_rd when empty is ignored, and rbr_data holds its last value.
- Simultaneous push+pop: level unchanged. When full, the push is accepted and there is no overrun. When empty, the push is accepted and the pop is ignored.
- Pointers wrap modulo DEPTH. rx_level saturates at capacity and never underflows.
- pe/fe: set on the cycle an entry carrying that flag becomes head. Cleared by lsr_rd unless set again in the same cycle, where set wins. oe is cleared by lsr_rd, except a same-cycle overrun wins.
- rx_fifo_err: errored-entry counter ≠ 0. The counter increments on push of an errored entry and decrements on pop of one.
- rx_fifo_clr: clears pointers, level, error counter, pe, fe and timeout next cycle. oe is kept. A push in the same cycle is dropped.
- rda_int = fifo_en ? (rx_level ≥ trigger) : dr. It is combinational from registered state.
- Timeout (fifo_en=1 only): counter cleared on push, pop, clear or empty; increments on char_tick while non-empty. At count TO_CHARS, cti_int=1 and the counter holds. cti_int is cleared by the next pop/push/clear. cti_int is always 0 when fifo_en=0.

Decomposition:
- uart_pkg holds:
  - rx_trig_e enum: TRIG_1, TRIG_4, TRIG_8, TRIG_14
  - trigger-to-count function
  - rx_entry_t struct {data, pe, fe}
  - default RX_FIFO_DEPTH, RX_TO_CHARS
- Sub-module uart_rx_timeout_counter: char_tick counter with clear/hold and the cti_int output.
- Storage is a flop array inside uart_rx_fifo_ctrl.

Test Plan:
- Push 0x5A (no errors), fifo_en=0 -> dr=1 next cycle, rbr_data=0x5A, rda_int=1; rbr_rd -> dr=0.
- fifo_en=1, rx_trig=01, push 0x01..0x04 -> rda_int rises after the 4th push with rx_level=4; pop all 4 -> data order 0x01..0x04, dr=0.
- Fill 16 entries, push 0xFF -> oe=1, rx_level=16, 0xFF never read. Repeat full with push+rbr_rd same cycle -> oe stays 0. lsr_rd clears oe.
- Push 0x10 clean, then 0x20 with parity_error=1 -> rx_fifo_err=1, pe=0. Pop once -> pe=1 with rbr_data=0x20. lsr_rd -> pe=0. Pop -> rx_fifo_err=0.
- fifo_en=1, push 1 byte, issue 4 char_tick -> cti_int=1 after the 4th. rbr_rd -> cti_int=0. A push at tick 3 restarts the count.
- Push 3 entries, assert presetn low mid-push and in a separate run pulse rx_fifo_clr -> rx_level=0, dr=0 (oe retained for clr only). Toggle fifo_en -> FIFO flushed.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    localparam int unsigned RX_FIFO_DEPTH = 16;
    localparam int unsigned RX_TO_CHARS   = 4;
    localparam int unsigned RX_DATA_W     = 8;

    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_4  = 2'b01,
        TRIG_8  = 2'b10,
        TRIG_14 = 2'b11
    } rx_trig_e;

    typedef struct packed {
        logic [RX_DATA_W-1:0] data;
        logic                 pe;
        logic                 fe;
    } rx_entry_t;

    function automatic int unsigned trig_count(rx_trig_e trig);
        case (trig)
            TRIG_1:  return 1;
            TRIG_4:  return 4;
            TRIG_8:  return 8;
            TRIG_14: return 14;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_timeout_counter.sv
// Character-time idle counter; raises cti_int after TO_CHARS idle ticks with data pending.
module uart_rx_timeout_counter
    import uart_pkg::*;
#(
    parameter int unsigned TO_CHARS = RX_TO_CHARS
) (
    input  logic pclk,
    input  logic presetn,
    input  logic utrrst,
    input  logic enable,
    input  logic clear,
    input  logic char_tick,
    output logic cti_int
);

    localparam int unsigned CW = $clog2(TO_CHARS + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || clear) begin
            cnt_d = '0;
        end else if (char_tick && (cnt_q != CW'(TO_CHARS))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= '0;
        end else if (utrrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cti_int = enable && (cnt_q == CW'(TO_CHARS));

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive FIFO / holding register with LSR receive status and RX interrupt requests.
// DATA_W must match uart_pkg::RX_DATA_W since entries use rx_entry_t.
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = RX_FIFO_DEPTH,
    parameter int unsigned DATA_W   = RX_DATA_W,
    parameter int unsigned TO_CHARS = RX_TO_CHARS
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       utrrst,
    input  logic                       fifo_en,
    input  logic                       rx_fifo_clr,
    input  logic [1:0]                 rx_trig,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rsr_data,
    input  logic                       parity_error,
    input  logic                       frame_error,
    input  logic                       char_tick,
    input  logic                       rbr_rd,
    input  logic                       lsr_rd,
    output logic [DATA_W-1:0]          rbr_data,
    output logic                       dr,
    output logic                       oe,
    output logic                       pe,
    output logic                       fe,
    output logic                       rx_fifo_err,
    output logic [$clog2(DEPTH):0]     rx_level,
    output logic                       rda_int,
    output logic                       cti_int
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    rx_entry_t       mem [DEPTH];
    rx_entry_t       head_q, head_d, wr_entry, next_head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, err_cnt_q, err_cnt_d, cap;
    logic            oe_q, oe_d, pe_q, pe_d, fe_q, fe_d, fifo_en_q;
    logic            flush, empty, full, push, pop, overrun, head_load;

    assign wr_entry = '{data: rsr_data, pe: parity_error, fe: frame_error};
    assign cap      = fifo_en ? CW'(DEPTH) : CW'(1);
    assign empty    = (count_q == '0);
    assign full     = (count_q >= cap);
    // A mode change discards contents exactly like an explicit clear.
    assign flush    = rx_fifo_clr || (fifo_en != fifo_en_q);
    assign pop      = rbr_rd && !empty && !flush;
    assign push     = rx_valid && !flush && (!full || pop);
    assign overrun  = rx_valid && !flush && full && !pop;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d   = count_q + CW'(push) - CW'(pop);
            err_cnt_d = err_cnt_q + CW'(push && (parity_error || frame_error))
                      - CW'(pop && (mem[rd_ptr_q].pe || mem[rd_ptr_q].fe));
        end
    end

    // New head is either the next stored entry or the entry being written this cycle.
    always_comb begin
        head_load = !flush && ((pop && (count_d != '0)) || (empty && push));
        next_head = (push && (wr_ptr_q == rd_ptr_d)) ? wr_entry : mem[rd_ptr_d];
        head_d    = head_load ? next_head : head_q;

        pe_d = flush ? 1'b0 : (head_load && next_head.pe) ? 1'b1 : lsr_rd ? 1'b0 : pe_q;
        fe_d = flush ? 1'b0 : (head_load && next_head.fe) ? 1'b1 : lsr_rd ? 1'b0 : fe_q;
        oe_d = overrun ? 1'b1 : lsr_rd ? 1'b0 : oe_q;
    end

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
            head_q    <= '0;
            oe_q      <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            fifo_en_q <= 1'b0;
        end else if (utrrst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
            head_q    <= '0;
            oe_q      <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            fifo_en_q <= fifo_en;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            head_q    <= head_d;
            oe_q      <= oe_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            fifo_en_q <= fifo_en;
        end
    end

    uart_rx_timeout_counter #(
        .TO_CHARS (TO_CHARS)
    ) u_timeout (
        .pclk      (pclk),
        .presetn   (presetn),
        .utrrst    (utrrst),
        .enable    (fifo_en),
        .clear     (push || pop || flush || empty),
        .char_tick (char_tick),
        .cti_int   (cti_int)
    );

    assign rbr_data    = head_q.data;
    assign dr          = !empty;
    assign oe          = oe_q;
    assign pe          = pe_q;
    assign fe          = fe_q;
    assign rx_fifo_err = (err_cnt_q != '0);
    assign rx_level    = count_q;
    assign rda_int     = fifo_en ? (32'(count_q) >= trig_count(rx_trig_e'(rx_trig))) : dr;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl against a queue-based reference model.
module tb_uart_rx_fifo_ctrl;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned TO_CHARS = 4;

    logic              pclk = 1'b0;
    logic              presetn, utrrst, fifo_en, rx_fifo_clr;
    logic [1:0]        rx_trig;
    logic              rx_valid;
    logic [DATA_W-1:0] rsr_data;
    logic              parity_error, frame_error, char_tick, rbr_rd, lsr_rd;
    logic [DATA_W-1:0] rbr_data;
    logic              dr, oe, pe, fe, rx_fifo_err, rda_int, cti_int;
    logic [4:0]        rx_level;

    int n_checks = 0;
    int n_err    = 0;

    always #5 pclk = ~pclk;

    uart_rx_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .TO_CHARS (TO_CHARS)
    ) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .utrrst       (utrrst),
        .fifo_en      (fifo_en),
        .rx_fifo_clr  (rx_fifo_clr),
        .rx_trig      (rx_trig),
        .rx_valid     (rx_valid),
        .rsr_data     (rsr_data),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .char_tick    (char_tick),
        .rbr_rd       (rbr_rd),
        .lsr_rd       (lsr_rd),
        .rbr_data     (rbr_data),
        .dr           (dr),
        .oe           (oe),
        .pe           (pe),
        .fe           (fe),
        .rx_fifo_err  (rx_fifo_err),
        .rx_level     (rx_level),
        .rda_int      (rda_int),
        .cti_int      (cti_int)
    );

    // Reference model: a queue of received characters plus LSR flags.
    typedef struct {
        logic [7:0] d;
        bit         p;
        bit         f;
    } ent_t;

    ent_t       mq[$];
    bit         m_oe, m_pe, m_fe, m_fen_prev;
    logic [7:0] m_rbr;
    int         m_idle;

    function automatic void model_reset(bit fen_prev);
        mq.delete();
        m_oe = 0; m_pe = 0; m_fe = 0;
        m_rbr = '0;
        m_idle = 0;
        m_fen_prev = fen_prev;
    endfunction

    function automatic void model_step();
        int  cap;
        bit  was_empty, popped, accepted, new_head;
        if (utrrst) begin
            model_reset(fifo_en);
            return;
        end
        if (rx_fifo_clr || (fifo_en != m_fen_prev)) begin
            mq.delete();
            m_pe = 0; m_fe = 0; m_idle = 0;
            if (lsr_rd) m_oe = 0;
            m_fen_prev = fifo_en;
            return;
        end
        cap       = fifo_en ? DEPTH : 1;
        was_empty = (mq.size() == 0);
        popped    = rbr_rd && !was_empty;
        accepted  = rx_valid && ((mq.size() < cap) || popped);
        if (popped) void'(mq.pop_front());
        if (accepted) mq.push_back('{d: rsr_data, p: parity_error, f: frame_error});
        new_head = (popped && mq.size() > 0) || (was_empty && accepted);
        if (new_head) m_rbr = mq[0].d;
        m_pe = (new_head && mq[0].p) ? 1'b1 : (lsr_rd ? 1'b0 : m_pe);
        m_fe = (new_head && mq[0].f) ? 1'b1 : (lsr_rd ? 1'b0 : m_fe);
        m_oe = (rx_valid && !accepted) ? 1'b1 : (lsr_rd ? 1'b0 : m_oe);
        if (!fifo_en || popped || accepted || was_empty) m_idle = 0;
        else if (char_tick && m_idle < TO_CHARS) m_idle++;
        m_fen_prev = fifo_en;
    endfunction

    function automatic bit exp_err();
        foreach (mq[i]) if (mq[i].p || mq[i].f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_rda();
        int trig;
        trig = (rx_trig == 2'd0) ? 1 : (rx_trig == 2'd1) ? 4 : (rx_trig == 2'd2) ? 8 : 14;
        return fifo_en ? (mq.size() >= trig) : (mq.size() > 0);
    endfunction

    function automatic bit exp_cti();
        return fifo_en && (m_idle == TO_CHARS);
    endfunction

    task automatic tick_clk();
        @(posedge pclk);
        model_step();
        #1;
        rx_valid = 0; rx_fifo_clr = 0; char_tick = 0; rbr_rd = 0; lsr_rd = 0;
        utrrst = 0; parity_error = 0; frame_error = 0;
    endtask

    task automatic push(input logic [7:0] d, input bit p = 0, input bit f = 0);
        rx_valid = 1; rsr_data = d; parity_error = p; frame_error = f;
        tick_clk();
    endtask

    task automatic pop();
        rbr_rd = 1;
        tick_clk();
    endtask

    task automatic test_reset();
        presetn = 0; utrrst = 0; fifo_en = 0; rx_fifo_clr = 0; rx_trig = 2'd0;
        rx_valid = 0; rsr_data = '0; parity_error = 0; frame_error = 0;
        char_tick = 0; rbr_rd = 0; lsr_rd = 0;
        model_reset(0);
        repeat (2) @(negedge pclk);
        n_checks++;
        if ({dr, oe, pe, fe, rx_fifo_err, rda_int, cti_int} !== 7'b0 || rx_level !== 5'd0
            || rbr_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: got flags=%b level=%0d data=%h expected all zero",
                     {dr, oe, pe, fe, rx_fifo_err, rda_int, cti_int}, rx_level, rbr_data);
        end
        presetn = 1;
        @(posedge pclk); #1;
    endtask

    task automatic test_nonfifo();
        fifo_en = 0;
        push(8'h5A);
        n_checks++;
        if (dr !== 1'b1 || rbr_data !== 8'h5A || rda_int !== 1'b1) begin
            n_err++;
            $display("FAIL nonfifo_push: got dr=%b data=%h rda=%b expected 1/5a/1", dr, rbr_data,
                     rda_int);
        end
        pop();
        n_checks++;
        if (dr !== 1'b0 || rda_int !== 1'b0) begin
            n_err++;
            $display("FAIL nonfifo_pop: got dr=%b rda=%b expected 0/0", dr, rda_int);
        end
    endtask

    task automatic test_trigger();
        fifo_en = 1; rx_trig = 2'b01;
        tick_clk();
        for (int i = 1; i <= 4; i++) begin
            push(8'(i));
            n_checks++;
            if (rda_int !== (i == 4) || rx_level !== 5'(i)) begin
                n_err++;
                $display("FAIL trig_push%0d: got rda=%b level=%0d expected %b/%0d", i, rda_int,
                         rx_level, (i == 4), i);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (rbr_data !== 8'(i) || rbr_data !== m_rbr) begin
                n_err++;
                $display("FAIL trig_order%0d: got %h expected %h", i, rbr_data, 8'(i));
            end
            pop();
        end
        n_checks++;
        if (dr !== 1'b0) begin
            n_err++;
            $display("FAIL trig_drain: got dr=%b expected 0", dr);
        end
    endtask

    task automatic test_overrun();
        rx_trig = 2'b00;
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        push(8'hFF);
        n_checks++;
        if (oe !== 1'b1 || rx_level !== 5'd16) begin
            n_err++;
            $display("FAIL ovr_full: got oe=%b level=%0d expected 1/16", oe, rx_level);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (rbr_data !== m_rbr || rbr_data === 8'hFF) begin
                n_err++;
                $display("FAIL ovr_read%0d: got %h expected %h", i, rbr_data, m_rbr);
            end
            pop();
        end
        lsr_rd = 1;
        tick_clk();
        n_checks++;
        if (oe !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_lsr_clear: got oe=%b expected 0", oe);
        end
        for (int i = 0; i < 16; i++) push(8'(i));
        rbr_rd = 1;
        push(8'hEE);
        n_checks++;
        if (oe !== 1'b0 || rx_level !== 5'd16 || rbr_data !== 8'h01) begin
            n_err++;
            $display("FAIL ovr_push_pop: got oe=%b level=%0d data=%h expected 0/16/01", oe,
                     rx_level, rbr_data);
        end
        rx_fifo_clr = 1;
        tick_clk();
    endtask

    task automatic test_errors();
        push(8'h10);
        push(8'h20, 1, 0);
        n_checks++;
        if (rx_fifo_err !== 1'b1 || pe !== 1'b0) begin
            n_err++;
            $display("FAIL err_push: got err=%b pe=%b expected 1/0", rx_fifo_err, pe);
        end
        pop();
        n_checks++;
        if (pe !== 1'b1 || rbr_data !== 8'h20 || fe !== 1'b0) begin
            n_err++;
            $display("FAIL err_head: got pe=%b fe=%b data=%h expected 1/0/20", pe, fe, rbr_data);
        end
        lsr_rd = 1;
        tick_clk();
        n_checks++;
        if (pe !== 1'b0 || rx_fifo_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_lsr: got pe=%b err=%b expected 0/1", pe, rx_fifo_err);
        end
        pop();
        n_checks++;
        if (rx_fifo_err !== 1'b0 || dr !== 1'b0) begin
            n_err++;
            $display("FAIL err_drain: got err=%b dr=%b expected 0/0", rx_fifo_err, dr);
        end
    endtask

    task automatic test_timeout();
        push(8'h33);
        for (int i = 1; i <= 5; i++) begin
            char_tick = 1;
            tick_clk();
            n_checks++;
            if (cti_int !== (i >= 4)) begin
                n_err++;
                $display("FAIL cto_tick%0d: got cti=%b expected %b", i, cti_int, (i >= 4));
            end
        end
        pop();
        n_checks++;
        if (cti_int !== 1'b0) begin
            n_err++;
            $display("FAIL cto_pop: got cti=%b expected 0", cti_int);
        end
        push(8'h44);
        repeat (2) begin char_tick = 1; tick_clk(); end
        char_tick = 1;
        push(8'h55);
        for (int i = 1; i <= 4; i++) begin
            char_tick = 1;
            tick_clk();
            n_checks++;
            if (cti_int !== (i == 4)) begin
                n_err++;
                $display("FAIL cto_restart%0d: got cti=%b expected %b", i, cti_int, (i == 4));
            end
        end
        rx_fifo_clr = 1;
        tick_clk();
        n_checks++;
        if (cti_int !== 1'b0 || rx_level !== 5'd0) begin
            n_err++;
            $display("FAIL cto_clr: got cti=%b level=%0d expected 0/0", cti_int, rx_level);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 17; i++) push(8'(i));
        rx_fifo_clr = 1;
        push(8'h77);
        n_checks++;
        if (rx_level !== 5'd0 || dr !== 1'b0 || oe !== 1'b1) begin
            n_err++;
            $display("FAIL clr_state: got level=%0d dr=%b oe=%b expected 0/0/1", rx_level, dr, oe);
        end
        push(8'h01); push(8'h02); push(8'h03);
        rx_valid = 1; rsr_data = 8'h04;
        #3 presetn = 0;
        model_reset(0);
        #1;
        n_checks++;
        if (rx_level !== 5'd0 || dr !== 1'b0 || oe !== 1'b0 || rbr_data !== 8'h00) begin
            n_err++;
            $display("FAIL rst_midpush: got level=%0d dr=%b oe=%b data=%h expected 0/0/0/00",
                     rx_level, dr, oe, rbr_data);
        end
        @(negedge pclk);
        rx_valid = 0;
        presetn = 1;
        tick_clk();
        push(8'hA1); push(8'hA2);
        fifo_en = 0;
        tick_clk();
        n_checks++;
        if (rx_level !== 5'd0 || dr !== 1'b0) begin
            n_err++;
            $display("FAIL mode_flush: got level=%0d dr=%b expected 0/0", rx_level, dr);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(199) == 0) fifo_en = ~fifo_en;
            if ($urandom_range(63) == 0) rx_trig = 2'($urandom_range(3));
            rx_fifo_clr  = ($urandom_range(99) == 0);
            utrrst       = ($urandom_range(499) == 0);
            rx_valid     = ($urandom_range(c % 600 < 300 ? 1 : 3) == 0);
            rsr_data     = 8'($urandom);
            parity_error = ($urandom_range(7) == 0);
            frame_error  = ($urandom_range(7) == 0);
            rbr_rd       = ($urandom_range(c % 600 < 300 ? 4 : 1) == 0);
            lsr_rd       = ($urandom_range(7) == 0);
            char_tick    = ($urandom_range(3) == 0);
            tick_clk();
            n_checks++;
            if (rx_level !== 5'(mq.size()) || dr !== (mq.size() > 0)) begin
                n_err++;
                $display("FAIL rand_level c=%0d: got level=%0d dr=%b expected %0d", c, rx_level,
                         dr, mq.size());
            end
            n_checks++;
            if (rbr_data !== m_rbr) begin
                n_err++;
                $display("FAIL rand_data c=%0d: got %h expected %h", c, rbr_data, m_rbr);
            end
            n_checks++;
            if ({oe, pe, fe, rx_fifo_err} !== {m_oe, m_pe, m_fe, exp_err()}) begin
                n_err++;
                $display("FAIL rand_lsr c=%0d: got oe/pe/fe/err=%b expected %b", c,
                         {oe, pe, fe, rx_fifo_err}, {m_oe, m_pe, m_fe, exp_err()});
            end
            n_checks++;
            if (rda_int !== exp_rda() || cti_int !== exp_cti()) begin
                n_err++;
                $display("FAIL rand_int c=%0d: got rda=%b cti=%b expected %b/%b", c, rda_int,
                         cti_int, exp_rda(), exp_cti());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nonfifo();
        test_trigger();
        test_overrun();
        test_errors();
        test_timeout();
        test_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
